// File: rtl/subtractor_nbit.sv
// Registered N-bit unsigned subtractor built as a ripple-borrow chain of full-subtractor cells.
// Define SUBTRACTOR_NBIT_OVF_EN to add the registered signed-overflow output ovf_o.
module subtractor_nbit #(
    parameter int unsigned nb_bit = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic              valid_o,
    output logic [nb_bit-1:0] diff_o,
`ifdef SUBTRACTOR_NBIT_OVF_EN
    output logic              ovf_o,
`endif
    output logic              borrow_o
);

    logic [nb_bit:0]   br;
    logic [nb_bit-1:0] d;

    logic              valid_d,  valid_q;
    logic [nb_bit-1:0] diff_d,   diff_q;
    logic              borrow_d, borrow_q;

    always_comb begin
        br = '0;
        d  = '0;
        for (int unsigned k = 0; k < nb_bit; k++) begin
            d[k]    = a_i[k] ^ b_i[k] ^ br[k];
            br[k+1] = (~a_i[k] & b_i[k]) | (~(a_i[k] ^ b_i[k]) & br[k]);
        end
    end

    // Results only load on valid_i; otherwise the last result is held.
    always_comb begin
        valid_d  = valid_i;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (valid_i) begin
            diff_d   = d;
            borrow_d = br[nb_bit];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign valid_o  = valid_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;

`ifdef SUBTRACTOR_NBIT_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (valid_i) begin
            ovf_d = (a_i[nb_bit-1] ^ b_i[nb_bit-1]) & (d[nb_bit-1] ^ a_i[nb_bit-1]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_nbit.sv
// Directed and exhaustive bench for subtractor_nbit at widths 8, 1 and 16.
// The overflow checks are compiled in when SUBTRACTOR_NBIT_OVF_EN is defined.
module tb_subtractor_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  a8, b8;
    logic [0:0]  a1, b1;
    logic [15:0] a16, b16;

    logic        valid8_o, borrow8_o;
    logic [7:0]  diff8_o;
    logic        valid1_o, borrow1_o;
    logic [0:0]  diff1_o;
    logic        valid16_o, borrow16_o;
    logic [15:0] diff16_o;
`ifdef SUBTRACTOR_NBIT_OVF_EN
    logic        ovf8_o, ovf1_o, ovf16_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subtractor_nbit #(.nb_bit(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .a_i(a8), .b_i(b8),
        .valid_o(valid8_o), .diff_o(diff8_o),
`ifdef SUBTRACTOR_NBIT_OVF_EN
        .ovf_o(ovf8_o),
`endif
        .borrow_o(borrow8_o)
    );

    subtractor_nbit #(.nb_bit(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .a_i(a1), .b_i(b1),
        .valid_o(valid1_o), .diff_o(diff1_o),
`ifdef SUBTRACTOR_NBIT_OVF_EN
        .ovf_o(ovf1_o),
`endif
        .borrow_o(borrow1_o)
    );

    subtractor_nbit #(.nb_bit(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .a_i(a16), .b_i(b16),
        .valid_o(valid16_o), .diff_o(diff16_o),
`ifdef SUBTRACTOR_NBIT_OVF_EN
        .ovf_o(ovf16_o),
`endif
        .borrow_o(borrow16_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; a8 = 8'h12; b8 = 8'h34;
        a1 = 1'b0; b1 = 1'b1; a16 = 16'h0001; b16 = 16'h0002;
        tick();
        tick();
        n_tests++;
        if ({valid8_o, borrow8_o, diff8_o} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset8: valid=%b borrow=%b diff=%h, want 0 0 00", valid8_o, borrow8_o, diff8_o);
        end
        n_tests++;
        if ({valid1_o, borrow1_o, diff1_o, valid16_o, borrow16_o, diff16_o} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset1_16: v1=%b br1=%b d1=%b v16=%b br16=%b d16=%h, want all 0",
                     valid1_o, borrow1_o, diff1_o, valid16_o, borrow16_o, diff16_o);
        end
`ifdef SUBTRACTOR_NBIT_OVF_EN
        n_tests++;
        if (ovf8_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: ovf=%b, want 0", ovf8_o);
        end
`endif
        rst = 1'b0; valid = 1'b0;
        tick();
    endtask

    task automatic test_boundaries();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vd [3];
        logic       vbr [3];
        va[0] = 8'hFF; vb[0] = 8'h00; vd[0] = 8'hFF; vbr[0] = 1'b0;
        va[1] = 8'h00; vb[1] = 8'hFF; vd[1] = 8'h01; vbr[1] = 1'b1;
        va[2] = 8'h80; vb[2] = 8'h80; vd[2] = 8'h00; vbr[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = va[i]; b8 = vb[i]; valid = 1'b1;
            tick();
            n_tests++;
            if ({valid8_o, borrow8_o, diff8_o} !== {1'b1, vbr[i], vd[i]}) begin
                n_fail++;
                $display("FAIL boundary%0d: %h-%h got v=%b br=%b d=%h, want v=1 br=%b d=%h",
                         i, va[i], vb[i], valid8_o, borrow8_o, diff8_o, vbr[i], vd[i]);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_hold();
        a8 = 8'h10; b8 = 8'h03; valid = 1'b1;
        tick();
        n_tests++;
        if ({valid8_o, borrow8_o, diff8_o} !== {1'b1, 1'b0, 8'h0D}) begin
            n_fail++;
            $display("FAIL hold_load: v=%b br=%b d=%h, want 1 0 0d", valid8_o, borrow8_o, diff8_o);
        end
        valid = 1'b0; a8 = 8'h01; b8 = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({valid8_o, borrow8_o, diff8_o} !== {1'b0, 1'b0, 8'h0D}) begin
                n_fail++;
                $display("FAIL hold%0d: v=%b br=%b d=%h, want 0 0 0d", i, valid8_o, borrow8_o, diff8_o);
            end
        end
    endtask

    task automatic test_reset_midstream();
        a8 = 8'h01; b8 = 8'h02; valid = 1'b1;
        tick();
        rst = 1'b1; a8 = 8'h30; b8 = 8'h10;
        tick();
        n_tests++;
        if ({valid8_o, borrow8_o, diff8_o} !== 10'h000) begin
            n_fail++;
            $display("FAIL mid_reset: v=%b br=%b d=%h, want 0 0 00", valid8_o, borrow8_o, diff8_o);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({valid8_o, borrow8_o, diff8_o} !== {1'b1, 1'b0, 8'h20}) begin
            n_fail++;
            $display("FAIL after_reset: v=%b br=%b d=%h, want 1 0 20", valid8_o, borrow8_o, diff8_o);
        end
        valid = 1'b0;
    endtask

    task automatic test_width1();
        logic [3:0] exp_tab;
        // index {a,b}: expected {borrow,diff}, listed for 00,01,10,11
        exp_tab = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] want;
            a1 = i[1]; b1 = i[0]; valid = 1'b1;
            case (i)
                0: want = 2'b00;
                1: want = 2'b11;
                2: want = 2'b01;
                default: want = 2'b00;
            endcase
            tick();
            n_tests++;
            if ({valid1_o, borrow1_o, diff1_o} !== {1'b1, want}) begin
                n_fail++;
                $display("FAIL w1_%0d: a=%b b=%b got v=%b br=%b d=%b, want v=1 br=%b d=%b",
                         i, a1, b1, valid1_o, borrow1_o, diff1_o, want[1], want[0]);
            end
        end
        valid = 1'b0;
        if (exp_tab != 4'b0000) $display("unexpected table state");
    endtask

    task automatic test_exhaustive8();
        valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            logic [8:0] ref9;
            a8 = i[15:8]; b8 = i[7:0];
            ref9 = {1'b0, a8} - {1'b0, b8};
            tick();
            n_tests++;
            if ({valid8_o, borrow8_o, diff8_o} !== {1'b1, ref9[8], ref9[7:0]}) begin
                n_fail++;
                $display("FAIL exh8: %h-%h got v=%b br=%b d=%h, want v=1 br=%b d=%h",
                         a8, b8, valid8_o, borrow8_o, diff8_o, ref9[8], ref9[7:0]);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_random16();
        valid = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [16:0] ref17;
            a16 = 16'($urandom);
            b16 = (i % 8 == 0) ? a16 : 16'($urandom);
            ref17 = {1'b0, a16} - {1'b0, b16};
            tick();
            n_tests++;
            if ({valid16_o, borrow16_o, diff16_o} !== {1'b1, ref17[16], ref17[15:0]}) begin
                n_fail++;
                $display("FAIL rand16: %h-%h got v=%b br=%b d=%h, want v=1 br=%b d=%h",
                         a16, b16, valid16_o, borrow16_o, diff16_o, ref17[16], ref17[15:0]);
            end
        end
        valid = 1'b0;
    endtask

`ifdef SUBTRACTOR_NBIT_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vd [3];
        logic       vo [3];
        va[0] = 8'h80; vb[0] = 8'h01; vd[0] = 8'h7F; vo[0] = 1'b1;
        va[1] = 8'h7F; vb[1] = 8'hFF; vd[1] = 8'h80; vo[1] = 1'b1;
        va[2] = 8'h05; vb[2] = 8'h03; vd[2] = 8'h02; vo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = va[i]; b8 = vb[i]; valid = 1'b1;
            tick();
            n_tests++;
            if ({diff8_o, ovf8_o} !== {vd[i], vo[i]}) begin
                n_fail++;
                $display("FAIL ovf%0d: %h-%h got d=%h ovf=%b, want d=%h ovf=%b",
                         i, va[i], vb[i], diff8_o, ovf8_o, vd[i], vo[i]);
            end
        end
        valid = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; valid = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_boundaries();
        test_hold();
        test_reset_midstream();
        test_width1();
`ifdef SUBTRACTOR_NBIT_OVF_EN
        test_ovf();
`endif
        test_exhaustive8();
        test_random16();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({valid8_o, borrow8_o, diff8_o, valid16_o, borrow16_o, diff16_o} !== 28'h0) begin
            n_fail++;
            $display("FAIL final_reset: v8=%b br8=%b d8=%h v16=%b br16=%b d16=%h, want all 0",
                     valid8_o, borrow8_o, diff8_o, valid16_o, borrow16_o, diff16_o);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
